// File: rtl/herloa_err_monitor_if.sv
// rtl/herloa_err_monitor_if.sv - sample and report handshake bundle for herloa_err_monitor
interface herloa_err_monitor_if #(
    parameter int WIDTH = 15,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   approx_sum;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] rpt_err_cnt;
    logic [ACC_W-1:0] rpt_ed_sum;
    logic [WIDTH:0]   rpt_max_ed;

    modport slave (
        input  in_valid, a, b, approx_sum, out_ready,
        output in_ready, out_valid, rpt_err_cnt, rpt_ed_sum, rpt_max_ed
    );

    modport master (
        output in_valid, a, b, approx_sum, out_ready,
        input  in_ready, out_valid, rpt_err_cnt, rpt_ed_sum, rpt_max_ed
    );
endinterface

// File: rtl/herloa_err_monitor.sv
// rtl/herloa_err_monitor.sv - windowed error-distance statistics for the HERLOA approximate adder
module herloa_err_monitor #(
    parameter int WIDTH  = 15,
    parameter int WINDOW = 256,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    herloa_err_monitor_if.slave    bus
);
    localparam int SW    = WIDTH + 1;
    localparam int SUM_W = ((ACC_W > SW) ? ACC_W : SW) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(WINDOW);

    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

    state_t           state, state_nx;
    logic             accept;
    logic             release_rpt;
    logic [CNT_W-1:0] samp_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [SW-1:0]    ed;
    logic             nz;
    logic             v1;
    logic [SW-1:0]    max_ed;
    logic [ACC_W-1:0] ed_sum;
    logic [SW-1:0]    exact_c;
    logic [SW-1:0]    ed_c;
    logic [SUM_W-1:0] sum_c;

    assign bus.in_ready  = (state == ACCUM)  && !rst;
    assign bus.out_valid = (state == REPORT) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign release_rpt   = bus.out_valid && bus.out_ready;

    assign bus.rpt_err_cnt = err_cnt;
    assign bus.rpt_ed_sum  = ed_sum;
    assign bus.rpt_max_ed  = max_ed;

    // Magnitude is formed by ordered subtraction so the difference never wraps.
    always_comb begin
        exact_c = SW'(bus.a) + SW'(bus.b);
        ed_c    = (exact_c >= bus.approx_sum) ? (exact_c - bus.approx_sum)
                                              : (bus.approx_sum - exact_c);
        sum_c   = SUM_W'(ed_sum) + SUM_W'(ed);
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (accept && samp_cnt == LAST) state_nx = DRAIN;
            DRAIN:   if (acc_cnt == FULL)            state_nx = REPORT;
            REPORT:  if (bus.out_ready)              state_nx = ACCUM;
            default:                                 state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            samp_cnt <= '0;
            acc_cnt  <= '0;
            err_cnt  <= '0;
            ed_sum   <= '0;
            max_ed   <= '0;
            ed       <= '0;
            nz       <= 1'b0;
            v1       <= 1'b0;
        end else begin
            state <= state_nx;
            v1    <= accept;
            ed    <= ed_c;
            nz    <= (ed_c != '0);
            // Stage 1 is empty in REPORT, so clearing never races an accumulate.
            if (release_rpt) begin
                samp_cnt <= '0;
                acc_cnt  <= '0;
                err_cnt  <= '0;
                ed_sum   <= '0;
                max_ed   <= '0;
            end else begin
                if (accept) samp_cnt <= samp_cnt + 1'b1;
                if (v1) begin
                    acc_cnt <= acc_cnt + 1'b1;
                    err_cnt <= err_cnt + CNT_W'(nz);
                    ed_sum  <= (sum_c > ACC_MAX) ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
                    if (ed > max_ed) max_ed <= ed;
                end
            end
        end
    end
endmodule
